// File: rtl/ship_pkg.sv
// Shared types for the player ship controller:
// FSM state encoding, sw_move bit indices, width helper.
package ship_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACTIVE    = 3'd1,
    S_HIT       = 3'd2,
    S_RESPAWN   = 3'd3,
    S_GAME_OVER = 3'd4
  } ship_state_e;

  localparam int MV_UP    = 0;
  localparam int MV_DOWN  = 1;
  localparam int MV_LEFT  = 2;
  localparam int MV_RIGHT = 3;

  function automatic int cnt_w(input int unsigned maxv);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((maxv >> i) != 0) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/ship_down_counter.sv
// Loadable down-counter that stops at zero.
// Used for fire cooldown and post-respawn immunity.
module ship_down_counter
  import ship_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/player_ship_ctrl.sv
// Player ship: movement, firing, lives and respawn FSM.
// Define SHIP_AUTOFIRE_EN for held-button autofire.
module player_ship_ctrl
  import ship_pkg::*;
#(
  parameter int POS_W         = 10,
  parameter int X_MIN         = 153,
  parameter int X_MAX         = 774,
  parameter int Y_MIN         = 65,
  parameter int Y_MAX         = 485,
  parameter int SPAWN_X       = 272,
  parameter int SPAWN_Y       = 273,
  parameter int STEP_DIV      = 100000,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_CYCLES = 500000,
  parameter int FIRE_COOLDOWN = 2000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       sw_move,
  input  logic             sw_fire,
  input  logic             hit_detected,
  output logic [POS_W-1:0] o_ship_x,
  output logic [POS_W-1:0] o_ship_y,
  output logic             fire,
  output logic [3:0]       lives,
  output logic [2:0]       o_state,
  output logic             o_invuln,
  output logic             game_over
);

  localparam int STEP_W = cnt_w(STEP_DIV - 1);
  localparam int INV_W  = cnt_w(INVULN_CYCLES);
  localparam int CD_W   = cnt_w(FIRE_COOLDOWN);

  localparam logic [POS_W-1:0] XMIN = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] XMAX = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YMIN = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YMAX = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] SX   = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0] SY   = POS_W'(SPAWN_Y);
  localparam logic [STEP_W-1:0] STEP_TC =
    STEP_W'(STEP_DIV - 1);

  ship_state_e       state, state_n;
  logic [POS_W-1:0]  x, y;
  logic [STEP_W-1:0] step;
  logic [3:0]        lives_q;
  logic              fire_q, go_q;
  logic              inv_zero, cd_zero;
  logic              inv_load;
  logic              hit_take, shot, step_tc;
  logic              up, dn, lf, rt;
  logic              arm_ok;

`ifdef SHIP_AUTOFIRE_EN
  assign arm_ok = 1'b1;
`else
  // A shot re-arms only after the button has been released.
  logic armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b1;
    end else if (shot) begin
      armed <= 1'b0;
    end else if (!sw_fire) begin
      armed <= 1'b1;
    end
  end

  assign arm_ok = armed;
`endif

  assign up      = sw_move[MV_UP];
  assign dn      = sw_move[MV_DOWN];
  assign lf      = sw_move[MV_LEFT];
  assign rt      = sw_move[MV_RIGHT];
  assign step_tc = (step == STEP_TC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    hit_take = 1'b0;
    shot     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sw_move != '0 || sw_fire) state_n = S_ACTIVE;
      end
      S_ACTIVE: begin
        hit_take = hit_detected && inv_zero;
        shot = sw_fire && !hit_take && cd_zero && arm_ok;
        if (hit_take) state_n = S_HIT;
      end
      S_HIT: begin
        state_n = (lives_q == 4'd1) ? S_GAME_OVER
                                    : S_RESPAWN;
      end
      S_RESPAWN:   state_n = S_IDLE;
      S_GAME_OVER: state_n = S_GAME_OVER;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= SX;
      y       <= SY;
      step    <= '0;
      lives_q <= 4'(LIVES_INIT);
      fire_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      fire_q <= shot;
      go_q   <= (state_n == S_GAME_OVER);
      if (state == S_HIT) lives_q <= lives_q - 4'd1;
      if (state == S_RESPAWN) begin
        x    <= SX;
        y    <= SY;
        step <= '0;
      end else if (state == S_ACTIVE && !hit_take) begin
        step <= step_tc ? '0 : step + 1'b1;
        if (step_tc) begin
          if (up && !dn && y > YMIN) y <= y - 1'b1;
          else if (dn && !up && y < YMAX) y <= y + 1'b1;
          if (lf && !rt && x > XMIN) x <= x - 1'b1;
          else if (rt && !lf && x < XMAX) x <= x + 1'b1;
        end
      end
    end
  end

  assign inv_load = (state == S_RESPAWN);

  ship_down_counter #(.W(INV_W)) u_invuln (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (inv_load),
    .value   (INV_W'(INVULN_CYCLES)),
    .zero    (inv_zero)
  );

  ship_down_counter #(.W(CD_W)) u_cooldown (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (shot),
    .value   (CD_W'(FIRE_COOLDOWN)),
    .zero    (cd_zero)
  );

  assign o_ship_x  = x;
  assign o_ship_y  = y;
  assign fire      = fire_q;
  assign lives     = lives_q;
  assign o_state   = state;
  assign o_invuln  = !inv_zero;
  assign game_over = go_q;

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Scoreboard bench for player_ship_ctrl: random and directed
// stimulus against a rule-level reference model.
module tb_player_ship_ctrl;

  localparam int STEP = 4;
  localparam int INV  = 20;
  localparam int CD   = 8;
  localparam int LIV  = 3;
  localparam int XMIN = 153;
  localparam int XMAX = 774;
  localparam int YMIN = 65;
  localparam int YMAX = 485;
  localparam int SPX  = 272;
  localparam int SPY  = 273;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       fire;
    logic [3:0] lives;
    logic [2:0] st;
    logic       inv;
    logic       go;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sw_move = '0;
  logic       sw_fire = 1'b0;
  logic       hit_detected = 1'b0;
  logic [9:0] o_ship_x, o_ship_y;
  logic       fire, o_invuln, game_over;
  logic [3:0] lives;
  logic [2:0] o_state;

  int vectors = 0;
  int miscompares = 0;
  obs_t q[$];

  int m_st, m_x, m_y, m_step, m_lives, m_inv, m_cd;
  bit m_armed, m_fire, m_go;

  player_ship_ctrl #(
    .POS_W(10), .STEP_DIV(STEP), .LIVES_INIT(LIV),
    .INVULN_CYCLES(INV), .FIRE_COOLDOWN(CD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_move(sw_move),
    .sw_fire(sw_fire), .hit_detected(hit_detected),
    .o_ship_x(o_ship_x), .o_ship_y(o_ship_y),
    .fire(fire), .lives(lives), .o_state(o_state),
    .o_invuln(o_invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic obs_t actual();
    obs_t a;
    a.x = o_ship_x; a.y = o_ship_y; a.fire = fire;
    a.lives = lives; a.st = o_state;
    a.inv = o_invuln; a.go = game_over;
    return a;
  endfunction

  function automatic obs_t expected();
    obs_t e;
    e.x = 10'(m_x); e.y = 10'(m_y); e.fire = m_fire;
    e.lives = 4'(m_lives); e.st = 3'(m_st);
    e.inv = (m_inv != 0); e.go = m_go;
    return e;
  endfunction

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic compare(string nm, obs_t a, obs_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t got x=%0d y=%0d fire=%0b lives=%0d st=%0d inv=%0b go=%0b need x=%0d y=%0d fire=%0b lives=%0d st=%0d inv=%0b go=%0b",
        nm, $time, a.x, a.y, a.fire, a.lives, a.st, a.inv, a.go,
        e.x, e.y, e.fire, e.lives, e.st, e.inv, e.go);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = SPX; m_y = SPY; m_step = 0;
    m_lives = LIV; m_inv = 0; m_cd = 0;
    m_armed = 1; m_fire = 0; m_go = 0;
  endtask

  // One clock of the game rules: ACTIVE=1, HIT=2, ...
  task automatic model_step(input logic [3:0] mv,
                            input logic f, input logic h);
    int nst, dx, dy;
    bit hit, shot;
    nst = m_st; hit = 0; shot = 0;
    if (m_st == 1) begin
      hit = h && (m_inv == 0);
`ifdef SHIP_AUTOFIRE_EN
      shot = f && !hit && (m_cd == 0);
`else
      shot = f && !hit && (m_cd == 0) && m_armed;
`endif
    end
    m_cd  = shot ? CD : (m_cd > 0 ? m_cd - 1 : 0);
    m_inv = (m_st == 3) ? INV : (m_inv > 0 ? m_inv - 1 : 0);
    if (shot) m_armed = 0;
    else if (!f) m_armed = 1;
    case (m_st)
      0: if (mv != 0 || f) nst = 1;
      1: begin
        if (hit) nst = 2;
        else if (m_step == STEP - 1) begin
          m_step = 0;
          dx = int'(mv[3]) - int'(mv[2]);
          dy = int'(mv[1]) - int'(mv[0]);
          m_x = clamp(m_x + dx, XMIN, XMAX);
          m_y = clamp(m_y + dy, YMIN, YMAX);
        end else m_step++;
      end
      2: begin
        m_lives--;
        nst = (m_lives == 0) ? 4 : 3;
      end
      3: begin
        m_x = SPX; m_y = SPY; m_step = 0; nst = 0;
      end
      default: ;
    endcase
    m_st = nst; m_fire = shot; m_go = (nst == 4);
  endtask

  task automatic cycle(input logic [3:0] mv,
                       input logic f, input logic h);
    @(negedge clk);
    sw_move = mv; sw_fire = f; hit_detected = h;
    model_step(mv, f, h);
    q.push_back(expected());
  endtask

  task automatic run(input logic [3:0] mv, input logic f,
                     input int n);
    for (int i = 0; i < n; i++) cycle(mv, f, 1'b0);
  endtask

  // Asynchronous reset, checked well before the next edge.
  task automatic do_reset(string nm);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    compare(nm, actual(), expected());
    @(negedge clk);
    sw_move = '0; sw_fire = 1'b0; hit_detected = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("cyc", actual(), e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    model_reset();
    #12;
    compare("reset", actual(), expected());
    @(negedge clk);
    reset_n = 1'b1;

    run(4'b0001, 1'b0, 40);
    run(4'b0001, 1'b0, 900);
    run(4'b0011, 1'b0, 20);
    run(4'b0100, 1'b0, 500);
    run(4'b1010, 1'b0, 40);

    run(4'b0000, 1'b1, 30);
    run(4'b0000, 1'b0, 3);
    run(4'b0000, 1'b1, 12);

    cycle(4'b0000, 1'b0, 1'b1);
    run(4'b0000, 1'b0, 4);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    run(4'b0001, 1'b0, 30);

    for (int k = 0; k < 3; k++) begin
      cycle(4'b1000, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b1);
      run(4'b0000, 1'b0, 25);
    end
    run(4'b1001, 1'b1, 20);
    cycle(4'b0000, 1'b0, 1'b1);
    do_reset("go_reset");

    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    do_reset("async_reset");
    cycle(4'b0000, 1'b1, 1'b0);
    run(4'b0000, 1'b1, 3);

    for (int b = 0; b < 6; b++) begin
      do_reset("blk_reset");
      for (int i = 0; i < 600; i++) begin
        cycle(4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 24) == 0));
      end
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
